radix_narrow_converter: RTL
===========================

// Module: radix_narrow_converter
// PURPOSE
// - Inverse of the SpMV widening converter: narrows IEEE-754 binary64 beats to binary32 or binary16 (or passes through) on the result/write-back path.
// - Valid/ready stream in, valid/ready stream out; 2-stage pipeline, self-contained RTL (no FP IP cores).
// - Narrow results are zero-extended into the low bits of the 64-bit output word, matching the packing the widening path consumes.
// PARAMETERS
// - none (formats fixed: binary64 -> binary32/binary16)
// PORTS
// clk           in   1   clock; single clock domain
// rstn          in   1   asynchronous, active-low reset
// Ctrl_sig      in   2   mode: 0 = fp64->fp16, 1 = fp64->fp32, 2 = pass-through, 3 = reserved (acts as 2)
// input_valid   in   1   input beat valid
// input_ready   out  1   input beat accepted when valid & ready
// input_data    in   64  binary64 operand
// output_valid  out  1   result valid
// output_ready  in   1   downstream ready
// output_data   out  64  result: fp16 in [15:0], fp32 in [31:0], fp64 in [63:0]; upper bits 0
// output_flags  out  3   per-beat {overflow, underflow, inexact}; qualified by output_valid
// BEHAVIOUR
// - Reset (async, rstn=0): both stage-valid bits 0 -> output_valid=0, output_data=0, output_flags=0; input_ready=1 one cycle after rstn rises.
// - Mode is sampled per beat at acceptance and carried down the pipe; changing Ctrl_sig never corrupts beats already accepted.
// - Latency: exactly 2 cycles from acceptance to output_valid with output_ready held 1; throughput 1 beat/cycle.
// - Handshake: S2 advances when !s2_valid | output_ready; S1 advances when !s1_valid | S2 advances; input_ready = S1 advances.
//   Pipeline holds at most 2 beats; no drops, no duplication, strict order; output_data/flags stable while valid & !ready.
// - S1: unpack sign/exp[10:0]/mant[51:0], classify, compute e = exp-1023 and target biased exponent, subnormal shift amount.
// - S2: round-to-nearest-even with guard + sticky, pack, generate flags.
// - Target: fp32 bias 127, 8b exp, 23b mant; fp16 bias 15, 5b exp, 10b mant.
// - Classes (narrow modes):
//   NaN (exp=0x7FF, mant!=0) -> canonical qNaN, sign 0: fp32 0x7FC00000, fp16 0x7E00; flags 0.
//   Inf (exp=0x7FF, mant=0) -> signed Inf; flags 0.
//   Zero or fp64 subnormal (exp=0) -> signed zero; inexact = (mant!=0), underflow = inexact.
//   Biased target exp >= max (255/31) -> signed Inf, overflow=1, inexact=1.
//   Normal range: RNE on mantissa; carry out of mantissa increments exponent; carry to max exp -> Inf + overflow.
//   Below min normal: denormalise with shift = 1 - biased_exp; shift > mant_width+1 -> signed zero (sticky only);
//     rounding may carry into min normal (legal, exponent field 1).
//   underflow = result tiny (pre-round) AND inexact; inexact = any discarded bit set.
// - Pass-through (2/3): output_data = input_data bit-exact, flags 0, same 2-cycle latency.
// - Reset mid-operation: in-flight beats discarded; no partial beat emitted after reset release.
// STRUCTURE
// - Shared package (spmv_fp_pkg): mode encodings RADIX_HALF=0 / RADIX_SINGLE=1 / RADIX_DOUBLE=2, per-format
//   EXP_W / MANT_W / BIAS constants, canonical qNaN constants, flag bit indices.
// - Sub-module fp64_narrow_round: combinational RNE/pack core parameterised by EXP_W/MANT_W/BIAS,
//   instanced twice (fp32, fp16) in S2, result muxed by carried mode.
// - Top holds the two stage registers, valid/ready control and class/shift computation.
// TESTING
// - mode1, 0x3FF0000000000000 (1.0) -> 0x000000003F800000, flags 000, output_valid exactly 2 cycles after accept.
// - mode0, 0x3FF5555555555555 -> 0x0000000000003D55, flags 001; mode0, 0x40EFFE0000000000 (65520) -> 0x7C00, flags 101.
// - mode1, 0x36A0000000000000 (2^-149) -> 0x00000001 flags 000; 0x3690000000000000 (2^-150, tie) -> 0x00000000 flags 011.
// - NaN/Inf: mode1 0x7FF0000000000001 -> 0x7FC00000; mode0 0xFFF0000000000000 -> 0xFC00; mode2 any -> bit-exact copy.
// - Backpressure: 4 beats offered back-to-back, output_ready=0 for 5 cycles -> input_ready drops after 2 accepts,
//   all 4 emerge in order, output held stable while stalled; Ctrl_sig toggled mid-stream -> each beat uses its own mode.
// - Assert rstn=0 with 2 beats in flight -> output_valid=0 immediately; after release no stale beat, next beat latency 2.

Source files
------------

// File: rtl/spmv_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spmv_fp_pkg
//  Purpose  : Shared encodings and format constants for the SpMV FP
//             widening/narrowing converters.
//  Revision : 1.0 - initial release
// ============================================================================
package spmv_fp_pkg;

    // Mode encodings carried with each beat
    localparam logic [1:0] RADIX_HALF   = 2'd0;
    localparam logic [1:0] RADIX_SINGLE = 2'd1;
    localparam logic [1:0] RADIX_DOUBLE = 2'd2;

    // Source format
    localparam int FP64_BIAS = 1023;

    // Target formats
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_BIAS   = 127;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;
    localparam int FP16_BIAS   = 15;

    // Canonical quiet NaNs (sign 0)
    localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
    localparam logic [15:0] QNAN16 = 16'h7E00;

    // Bit positions inside the 3-bit flag vector {overflow, underflow, inexact}
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // Operand class as seen from the binary64 encoding
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,   // zero or fp64 subnormal (both flush to signed zero)
        CLS_NUM  = 2'd1,   // normal number
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    function automatic fp_class_t classify(input logic [10:0] exp_f, input logic [51:0] mant_f);
        if (exp_f == 11'h7FF)
            return (mant_f != 52'd0) ? CLS_NAN : CLS_INF;
        else if (exp_f == 11'd0)
            return CLS_ZERO;
        else
            return CLS_NUM;
    endfunction

    // Right-shift needed to denormalise into the target; 0 when the value is
    // a target normal, saturated at mant_w+2 (everything becomes sticky).
    function automatic logic [5:0] sub_shift(input logic signed [12:0] e_unb,
                                             input int bias, input int mant_w);
        int s;
        s = 1 - (int'(e_unb) + bias);
        if (s < 0)
            s = 0;
        if (s > mant_w + 2)
            s = mant_w + 2;
        return 6'(s);
    endfunction

endpackage : spmv_fp_pkg
`default_nettype wire

// File: rtl/fp64_narrow_round.sv
`default_nettype none
// ============================================================================
//  Module   : fp64_narrow_round
//  Purpose  : Combinational round-to-nearest-even and pack of a classified
//             binary64 operand into a narrower IEEE format, with flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fp64_narrow_round
    import spmv_fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127,
    parameter logic [EXP_W+MANT_W:0] QNAN = '0
) (
    input  logic                     sign,
    input  fp_class_t                cls,
    input  logic [51:0]              mant,
    input  logic signed [12:0]       e_unb,   // unbiased exponent
    input  logic [5:0]               shift,   // denormalising shift (0 if normal)
    output logic [EXP_W+MANT_W:0]    result,
    output logic [2:0]               flags
);

    localparam int W = 53 + MANT_W + 2;
    localparam logic signed [12:0] BIAS_S    = 13'(BIAS);
    localparam logic signed [12:0] EXP_MAX_S = 13'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]   EXP_ONES  = '1;

    logic signed [12:0] bexp;
    logic               tiny;
    logic [W-1:0]       wide;
    logic [MANT_W:0]    keep;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic               inexact;
    logic [MANT_W+1:0]  rounded;
    logic [EXP_W:0]     exp_inc;

    // Align, round and pack according to the operand class
    always_comb begin
        result   = '0;
        flags    = '0;
        bexp     = e_unb + BIAS_S;
        tiny     = (bexp < 13'sd1);
        // Shift 0 keeps hidden bit at the top; tiny values slide right into the
        // subnormal position, shifted-out bits collect into guard/sticky.
        wide     = {1'b1, mant, {(MANT_W+2){1'b0}}} >> (tiny ? shift : 6'd0);
        keep     = wide[W-1 -: MANT_W+1];
        guard    = wide[W-MANT_W-2];
        sticky   = |wide[W-MANT_W-3:0];
        inexact  = guard | sticky;
        round_up = guard & (sticky | keep[0]);
        rounded  = {1'b0, keep} + {{(MANT_W+1){1'b0}}, round_up};
        exp_inc  = {1'b0, bexp[EXP_W-1:0]} + {{EXP_W{1'b0}}, 1'b1};

        case (cls)
            CLS_NAN: begin
                result = QNAN;
            end
            CLS_INF: begin
                result = {sign, EXP_ONES, {MANT_W{1'b0}}};
            end
            CLS_ZERO: begin
                result          = {sign, {(EXP_W+MANT_W){1'b0}}};
                flags[FLAG_INX] = (mant != 52'd0);
                flags[FLAG_UNF] = (mant != 52'd0);
            end
            default: begin
                if (bexp >= EXP_MAX_S) begin
                    result          = {sign, EXP_ONES, {MANT_W{1'b0}}};
                    flags[FLAG_OVF] = 1'b1;
                    flags[FLAG_INX] = 1'b1;
                end else if (tiny) begin
                    // A carry into bit MANT_W lands exactly on the min normal
                    result = {sign, {(EXP_W-1){1'b0}}, rounded[MANT_W], rounded[MANT_W-1:0]};
                    flags[FLAG_INX] = inexact;
                    flags[FLAG_UNF] = inexact;
                end else if (rounded[MANT_W+1]) begin
                    // Mantissa overflowed: bump exponent, fraction wraps to 0
                    if (exp_inc[EXP_W-1:0] == EXP_ONES) begin
                        result          = {sign, EXP_ONES, {MANT_W{1'b0}}};
                        flags[FLAG_OVF] = 1'b1;
                    end else begin
                        result = {sign, exp_inc[EXP_W-1:0], {MANT_W{1'b0}}};
                    end
                    flags[FLAG_INX] = 1'b1;
                end else begin
                    result          = {sign, bexp[EXP_W-1:0], rounded[MANT_W-1:0]};
                    flags[FLAG_INX] = inexact;
                end
            end
        endcase
    end

endmodule : fp64_narrow_round
`default_nettype wire

// File: rtl/radix_narrow_converter.sv
`default_nettype none
// ============================================================================
//  Module   : radix_narrow_converter
//  Purpose  : Two-stage valid/ready pipeline narrowing binary64 beats to
//             binary32 / binary16 (or passing them through), results
//             zero-extended into a 64-bit word with {ovf, unf, inx} flags.
//  Revision : 1.0 - initial release
// ============================================================================
module radix_narrow_converter
    import spmv_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  Ctrl_sig,
    input  logic        input_valid,
    output logic        input_ready,
    input  logic [63:0] input_data,
    output logic        output_valid,
    input  logic        output_ready,
    output logic [63:0] output_data,
    output logic [2:0]  output_flags
);

    // Stage-1 unpack of the incoming operand
    logic signed [12:0] e_in;
    fp_class_t          cls_in;
    logic [5:0]         shift32_in;
    logic [5:0]         shift16_in;

    assign e_in       = $signed({2'b00, input_data[62:52]}) - 13'(FP64_BIAS);
    assign cls_in     = classify(input_data[62:52], input_data[51:0]);
    assign shift32_in = sub_shift(e_in, FP32_BIAS, FP32_MANT_W);
    assign shift16_in = sub_shift(e_in, FP16_BIAS, FP16_MANT_W);

    // Pipeline handshake
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv      = !s2_valid || output_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign input_ready = s1_adv;

    // Stage-1 registers
    logic [1:0]         s1_mode;
    logic [63:0]        s1_data;
    fp_class_t          s1_cls;
    logic signed [12:0] s1_e;
    logic [5:0]         s1_shift32;
    logic [5:0]         s1_shift16;

    // Capture an accepted beat together with its mode and unpacked fields
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid   <= 1'b0;
            s1_mode    <= RADIX_HALF;
            s1_data    <= '0;
            s1_cls     <= CLS_ZERO;
            s1_e       <= '0;
            s1_shift32 <= '0;
            s1_shift16 <= '0;
        end else if (s1_adv) begin
            s1_valid   <= input_valid;
            s1_mode    <= Ctrl_sig;
            s1_data    <= input_data;
            s1_cls     <= cls_in;
            s1_e       <= e_in;
            s1_shift32 <= shift32_in;
            s1_shift16 <= shift16_in;
        end
    end

    // Stage-2 rounding cores
    logic [31:0] r32;
    logic [2:0]  f32;
    logic [15:0] r16;
    logic [2:0]  f16;

    fp64_narrow_round #(
        .EXP_W  (FP32_EXP_W),
        .MANT_W (FP32_MANT_W),
        .BIAS   (FP32_BIAS),
        .QNAN   (QNAN32)
    ) u_round32 (
        .sign   (s1_data[63]),
        .cls    (s1_cls),
        .mant   (s1_data[51:0]),
        .e_unb  (s1_e),
        .shift  (s1_shift32),
        .result (r32),
        .flags  (f32)
    );

    fp64_narrow_round #(
        .EXP_W  (FP16_EXP_W),
        .MANT_W (FP16_MANT_W),
        .BIAS   (FP16_BIAS),
        .QNAN   (QNAN16)
    ) u_round16 (
        .sign   (s1_data[63]),
        .cls    (s1_cls),
        .mant   (s1_data[51:0]),
        .e_unb  (s1_e),
        .shift  (s1_shift16),
        .result (r16),
        .flags  (f16)
    );

    logic [63:0] s2_data_nxt;
    logic [2:0]  s2_flags_nxt;

    // Select the result for the mode the beat was accepted with
    always_comb begin
        s2_data_nxt  = s1_data;
        s2_flags_nxt = 3'b000;
        case (s1_mode)
            RADIX_HALF: begin
                s2_data_nxt  = {48'd0, r16};
                s2_flags_nxt = f16;
            end
            RADIX_SINGLE: begin
                s2_data_nxt  = {32'd0, r32};
                s2_flags_nxt = f32;
            end
            default: begin
                s2_data_nxt  = s1_data;
                s2_flags_nxt = 3'b000;
            end
        endcase
    end

    // Output register; holds while downstream stalls
    logic [63:0] s2_data;
    logic [2:0]  s2_flags;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_flags <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_data  <= s2_data_nxt;
            s2_flags <= s2_flags_nxt;
        end
    end

    assign output_valid = s2_valid;
    assign output_data  = s2_data;
    assign output_flags = s2_flags;

endmodule : radix_narrow_converter
`default_nettype wire
